// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: FSM state encodings and the
// opcode constants used by the downstream ALU.
package alu_operand_loader_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_A  = 2'b00,
        ST_WAIT_B  = 2'b01,
        ST_WAIT_OP = 2'b10,
        ST_FULL    = 2'b11
    } state_e;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Switch/button inputs, ACK and the registered operand outputs of the loader.
interface alu_operand_loader_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 6
);
    logic [WIDTH-1:0] sw;
    logic             load;
    logic             clr;
    logic             ack;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             valid;
    logic [1:0]       state;

    modport master (
        output sw, load, clr, ack,
        input  a, b, op, valid, state
    );

    modport slave (
        input  sw, load, clr, ack,
        output a, b, op, valid, state
    );
endinterface

// File: rtl/alu_operand_loader_btn_debounce.sv
// Level debouncer: the filtered output follows the input only after DB_CYCLES
// consecutive samples differ from the current filtered level.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic level_i,
    output logic level_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        // Any sample matching the current level restarts the count.
        if (level_i != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = level_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/alu_operand_loader.sv
// Captures A, B and opcode from the switches on successive LOAD presses and
// raises VALID until ACK. Define DEBOUNCE_EN to filter LOAD through btn_debounce.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OPW       = 6,
    parameter int DB_CYCLES = 16
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    alu_operand_loader_if.slave io_if
);
    logic [1:0]       load_sync_q, clr_sync_q;
    logic             load_level, load_prev_q, load_pulse, clr_s;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             valid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_sync_q <= '0;
            clr_sync_q  <= '0;
        end else begin
            load_sync_q <= {load_sync_q[0], io_if.load};
            clr_sync_q  <= {clr_sync_q[0], io_if.clr};
        end
    end

    assign clr_s = clr_sync_q[1];

`ifdef DEBOUNCE_EN
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .level_i (load_sync_q[1]),
        .level_o (load_level)
    );
`else
    logic unused_db_cycles;
    assign unused_db_cycles = (DB_CYCLES == 0);
    assign load_level       = load_sync_q[1];
`endif

    assign load_pulse = load_level & ~load_prev_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_WAIT_A:  if (load_pulse) begin a_d = io_if.sw; state_d = ST_WAIT_B; end
            ST_WAIT_B:  if (load_pulse) begin b_d = io_if.sw; state_d = ST_WAIT_OP; end
            ST_WAIT_OP: if (load_pulse) begin op_d = io_if.sw[OPW-1:0]; state_d = ST_FULL; end
            // A press arriving together with ACK is dropped.
            ST_FULL:    if (io_if.ack) state_d = ST_WAIT_A;
            default:    state_d = ST_WAIT_A;
        endcase
        if (clr_s) begin
            state_d = ST_WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_prev_q <= 1'b0;
            state_q     <= ST_WAIT_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            load_prev_q <= load_level;
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            valid_q     <= (state_d == ST_FULL);
        end
    end

    assign io_if.a     = a_q;
    assign io_if.b     = b_q;
    assign io_if.op    = op_q;
    assign io_if.valid = valid_q;
    assign io_if.state = state_q;
endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end stage of the TP1 ALU datapath. Captures operand A, operand B and a 6-bit opcode from the board switches, one per LOAD button press, in that fixed order, and holds them stable on registered outputs. A VALID/ACK handshake tells the combinational ALU (ADD/SUB/…) and its result register when the operand set is complete.

## Interface

Parameters:
- WIDTH, 8, operand width; matches the ALU data width.
- OPW, 6, opcode width.
- DB_CYCLES, 16, stable cycles required by the debouncer; used only with DEBOUNCE_EN.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SW  in  WIDTH  switch bank; sampled unsynchronized on the capture edge; user keeps it stable while pressing LOAD.
- LOAD  in  1  raw push-button; each press captures one field.
- CLR  in  1  raw push-button, level; synchronous clear after synchronization.
- ACK  in  1  downstream consumed the operand set; honoured only while VALID=1.
- A  out  WIDTH  operand A register.
- B  out  WIDTH  operand B register.
- OP  out  OPW  opcode register, SW[OPW-1:0] at capture.
- VALID  out  1  registered; high while A, B and OP are all loaded.
- STATE  out  2  current FSM state, for LED debug.

## Operation

- Reset, asynchronous: A=0, B=0, OP=0, VALID=0, STATE=WAIT_A (2'b00). Takes effect immediately mid-sequence. Release is sampled on the next CLK edge.
- LOAD and CLR each pass through a 2-flop synchronizer.
- LOAD then drives a rising-edge detector. The edge detector produces a single-cycle load_pulse.
- FSM states and transitions:
  - WAIT_A (00): on load_pulse, A<=SW, go to WAIT_B.
  - WAIT_B (01): on load_pulse, B<=SW, go to WAIT_OP.
  - WAIT_OP (10): on load_pulse, OP<=SW[OPW-1:0], go to FULL.
  - FULL (11): VALID=1. load_pulse is ignored. On ACK, go to WAIT_A.
- VALID is exactly (STATE==FULL), registered alongside the state.
- In FULL, ACK clears VALID on the next edge. A, B and OP keep their values until overwritten by the next sequence.
- ACK outside FULL is ignored.
- Synchronized CLR is the highest-priority synchronous event. It forces A=B=OP=0 and WAIT_A, with VALID=0 on the next edge.
- Simultaneous events:
  - CLR with load_pulse or ACK: CLR wins.
  - load_pulse and ACK in FULL: ACK wins, and the press is dropped.
- A held LOAD produces one capture only. A new capture needs a release and a new press.

## Timing

- Without DEBOUNCE_EN: LOAD rising before edge n updates the register and STATE on edge n+2, i.e. 3 edges counting n.
- With DEBOUNCE_EN: add DB_CYCLES edges.
- CLR effect: registers zero on the 3rd edge after assertion. CLR is never debounced.
- ACK to VALID low: 1 edge.
- Last load_pulse to VALID high: same edge as the OP capture.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- DEBOUNCE_EN defined: the synchronized LOAD passes through btn_debounce before edge detection. The filtered level changes only after DB_CYCLES consecutive identical samples. Any bounce restarts the count.
- DEBOUNCE_EN undefined: the synchronized LOAD feeds the edge detector directly. DB_CYCLES is unused and no counter is synthesized.

## Structure

- Shared include alu_defs.vh holds:
  - State encodings ST_WAIT_A/ST_WAIT_B/ST_WAIT_OP/ST_FULL.
  - Opcode constants OP_ADD=6'b100000 and OP_SUB=6'b100010, used by the ALU and the bench.
- One sub-module, btn_debounce, with CLK/RST_N, parameter DB_CYCLES, a level input and a filtered level output. It is instantiated only under DEBOUNCE_EN.

## Test plan

- Reset, then press LOAD with SW=0x2A, 0x0F, 0x22 → A=0x2A, B=0x0F, OP=6'b100010, VALID=1, STATE=11; the downstream SUB gives 0x1B.
- With VALID=1, press LOAD (SW=0xFF) → A/B/OP unchanged. Then pulse ACK → VALID=0 next edge, STATE=00, A still 0x2A.
- After loading A=0x55, assert CLR together with a LOAD press → A=B=OP=0, STATE=00, and the press is not captured.
- Assert RST_N=0 in WAIT_OP, away from any clock edge → outputs zero immediately, without waiting for CLK.
- Hold LOAD high for 50 cycles in WAIT_A → exactly one capture, STATE=01.
- With DEBOUNCE_EN and DB_CYCLES=16, toggle LOAD every 5 cycles for 40 cycles, then hold high → no capture during the bounce, then a single capture 3+16 edges after the level settles.
